// File: rtl/exec_stage.sv
// Execute stage: ALU ops plus an iterative multiplier and an optional divider.
// Latency: 1 cycle for ALU/NOP/unknown ops, 32 cycles after acceptance for MUL/DIVU/REMU.
// Backpressure: in_ready drops for the whole iterative op; in_valid is ignored until it rises.
//
// Ports:
//   clk, rst                  - clock and asynchronous active-low reset
//   in_valid/in_ready         - operation handshake from decode
//   alu_op, src1, src2        - opcode and operands
//   wraddr, wreg              - destination register and write flag
//   wb_valid                  - one-cycle result pulse
//   wb_en, wb_addr, wb_data   - register-file write port (addr/data hold between results)
//
// Build option: define EXEC_DIV_EN to add DIVU/REMU (restoring divider). Without it
// those opcodes complete as unknown ops.

module exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [4:0]  wraddr,
  input  logic        wreg,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_SLTU = 6'h07;
  localparam logic [5:0] OP_SLL  = 6'h08;
  localparam logic [5:0] OP_SRL  = 6'h09;
  localparam logic [5:0] OP_SRA  = 6'h0A;
  localparam logic [5:0] OP_MUL  = 6'h10;
`ifdef EXEC_DIV_EN
  localparam logic [5:0] OP_DIVU = 6'h11;
  localparam logic [5:0] OP_REMU = 6'h12;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  // Fields of an iterative op kept for its writeback.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] addr;
    logic       wreg;
  } cap_t;

  state_t      state_q, state_d;
  cap_t        cap_q;
  logic [4:0]  cnt_q;
  logic        accept;
  logic        done;

  // Iteration registers: acc is the product (MUL) or partial remainder (DIV);
  // opa is the shifting multiplicand or the dividend/quotient shift register;
  // opb is the shifting multiplier or the fixed divisor.
  logic [31:0] acc_q, opa_q, opb_q;
  logic [31:0] acc_nx, opa_nx, opb_nx;
  logic [31:0] multi_result;
`ifdef EXEC_DIV_EN
  logic [31:0] src1_q;
  logic [32:0] rem_sh;
  logic [32:0] diff;
`endif

  function automatic logic [31:0] alu_single(input logic [5:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'b0, (a < b)};
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only real ALU ops may write; NOP and unknown codes never do.
  function automatic logic op_writes(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_SRA);
  endfunction

  function automatic logic op_multi(input logic [5:0] op);
`ifdef EXEC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

  // in_ready is gated by rst so it reads 0 for the whole reset window.
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    in_ready = rst && (state_q == IDLE);
    case (state_q)
      IDLE: if (accept && op_multi(alu_op)) state_d = BUSY;
      BUSY: begin
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration step per BUSY edge.
  always_comb begin
    acc_nx       = acc_q;
    opa_nx       = opa_q;
    opb_nx       = opb_q;
    multi_result = '0;
`ifdef EXEC_DIV_EN
    rem_sh = {acc_q, opa_q[31]};
    diff   = rem_sh - {1'b0, opb_q};
`endif
    if (cap_q.op == OP_MUL) begin
      acc_nx       = opb_q[0] ? (acc_q + opa_q) : acc_q;
      opa_nx       = opa_q << 1;
      opb_nx       = opb_q >> 1;
      multi_result = acc_nx;
    end
`ifdef EXEC_DIV_EN
    else begin
      if (rem_sh >= {1'b0, opb_q}) begin
        acc_nx = diff[31:0];
        opa_nx = {opa_q[30:0], 1'b1};
      end else begin
        acc_nx = rem_sh[31:0];
        opa_nx = {opa_q[30:0], 1'b0};
      end
      // Zero divisor gets fixed results rather than whatever the iteration leaves.
      if (cap_q.op == OP_DIVU) multi_result = (opb_q == '0) ? 32'hFFFF_FFFF : opa_nx;
      else                     multi_result = (opb_q == '0) ? src1_q : acc_nx;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
`ifdef EXEC_DIV_EN
      src1_q   <= '0;
`endif
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      if (accept) begin
        if (op_multi(alu_op)) begin
          cap_q <= '{op: alu_op, addr: wraddr, wreg: wreg};
          cnt_q <= '0;
          acc_q <= '0;
          opa_q <= src1;
          opb_q <= src2;
`ifdef EXEC_DIV_EN
          src1_q <= src1;
`endif
        end else begin
          wb_valid <= 1'b1;
          wb_en    <= wreg && (wraddr != 5'd0) && op_writes(alu_op);
          wb_addr  <= wraddr;
          wb_data  <= alu_single(alu_op, src1, src2);
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= acc_nx;
        opa_q <= opa_nx;
        opb_q <= opb_nx;
        if (done) begin
          wb_valid <= 1'b1;
          wb_en    <= cap_q.wreg && (cap_q.addr != 5'd0);
          wb_addr  <= cap_q.addr;
          wb_data  <= multi_result;
        end
      end
    end
  end

endmodule
